// File: rtl/bcd_down_chain.sv
// -----------------------------------------------------------------------------
// bcd_down_chain
//
// Multi-digit BCD down-counter built as a single borrow chain. Each digit wraps
// to 9 on borrow, or to 5 when its WRAP5_MASK bit is set (minutes:seconds style
// timers). Presets are loaded in parallel with per-digit clamping of codes
// 10..15 to 9. The counter stops at zero and flags terminal count.
//
// Optional feature (compile-time macro BCD_DOWN_CHAIN_AUTO_RELOAD_EN):
//   When defined, the last loaded (clamped) preset is kept in a reload register
//   and counting from all-zero reloads it, which turns the block into a
//   periodic timer. When undefined, the counter holds at zero (one-shot).
//
// Parameters:
//   DIGITS      number of BCD digits, 1..8
//   WRAP5_MASK  bit i set -> digit i wraps 0->5, else 0->9
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   enablen  in   active-low count enable (one decrement per clock)
//   load     in   synchronous parallel load of in
//   in       in   preset, digit i at in[4i+3:4i]
//   count    out  registered count, same packing as in
//   rco_L    out  active-low terminal count (low when count is all zero)
//   done     out  one-cycle pulse after a decrement lands on all-zero
// -----------------------------------------------------------------------------
module bcd_down_chain #(
    parameter int                DIGITS     = 4,
    parameter logic [DIGITS-1:0] WRAP5_MASK = 4'b0010
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enablen,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   in,
    output logic [4*DIGITS-1:0]   count,
    output logic                  rco_L,
    output logic                  done
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                done_q, done_d;
    logic [4*DIGITS-1:0] in_clamped;
    logic [4*DIGITS-1:0] count_dec;
    logic                all_zero;

    // Clamp every digit code above 9 down to 9; legal codes pass unchanged.
    function automatic logic [4*DIGITS-1:0] clamp_in(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // One step of the borrow chain. Digit 0 always steps; a higher digit steps
    // only when every lower digit was 0 before this step.
    function automatic logic [4*DIGITS-1:0] dec_chain(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = WRAP5_MASK[i] ? 4'd5 : 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                end
            end
            borrow = borrow & (v[4*i +: 4] == 4'd0);
        end
        return r;
    endfunction

    assign in_clamped = clamp_in(in);
    assign count_dec  = dec_chain(count_q);
    assign all_zero   = (count_q == '0);

`ifdef BCD_DOWN_CHAIN_AUTO_RELOAD_EN
    logic [4*DIGITS-1:0] reload_q;

    // Remembers the most recent clamped preset for periodic reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= in_clamped;
        end
    end
`endif

    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            count_d = in_clamped;
        end else if (!enablen) begin
            if (!all_zero) begin
                count_d = count_dec;
                // Only a real decrement that lands on zero raises done.
                done_d  = (count_dec == '0);
            end else begin
`ifdef BCD_DOWN_CHAIN_AUTO_RELOAD_EN
                count_d = reload_q;
`else
                count_d = count_q;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;
    assign rco_L = !all_zero;

endmodule

// File: doc/bcd_down_chain.md
# bcd_down_chain

Parametrised multi-digit BCD down-counter: the general successor to the per-digit timer counters. It chains `DIGITS` decimal digits into one borrow chain, with a per-digit wrap modulus (9 or 5). It loads preset values, counts down to zero, and flags terminal count. It sits inside the timer level and drives the display digits directly, e.g. a mm:ss microwave-style timer.

## Interface
- `DIGITS`, default 4: number of BCD digits in the chain, 1..8.
- `WRAP5_MASK`, default `4'b0010`: bit i set means digit i wraps 0→5 on borrow; clear means it wraps 0→9. Width is `DIGITS`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enablen` input 1: active-low count enable; one decrement per clock while low.
- `load` input 1: synchronous parallel load of `in`.
- `in` input 4*DIGITS: preset value; digit i is `in[4i+3:4i]`.
- `count` output 4*DIGITS: current registered value, same digit packing as `in`.
- `rco_L` output 1: active-low terminal count; low exactly when every digit of `count` is 0.
- `done` output 1: registered one-cycle pulse when a decrement lands on all-zero.

## Operation
- Priority per clock edge: `rst` > `load` > count (`enablen` low) > hold.
- Reset: `count` = 0, `done` = 0; `rco_L` = 0 as a consequence.
- Load clamping: each loaded digit with code 10..15 is clamped to 9.
  - Codes 0..9 are stored as-is, including 6..9 into a wrap-5 digit.
  - An over-range wrap-5 digit (e.g. seconds "75") counts down normally from its value. Only after reaching 0 and borrowing does it wrap to 5.
- Decrement, when the chain is not all-zero:
  - Digit 0 always steps.
  - Digit i (i>0) steps only when digits 0..i-1 are all 0.
  - A step from nonzero v gives v−1.
  - A step from 0 gives 5 if `WRAP5_MASK[i]` is set, else 9.
- Terminal: when all digits are 0 and `enablen` is low, `count` holds at 0 with no wrap. Behaviour under `BCD_DOWN_CHAIN_AUTO_RELOAD_EN` is in Configuration.
- `done` = 1 for one cycle after an edge where a decrement moved `count` from nonzero to all-zero.
  - It is not raised by reset.
  - It is not raised by loading 0.
  - It is not raised while holding at zero.
- `rco_L` is combinational from `count` and needs no `enablen` qualification.

## Timing
- Load latency: `count` = clamped `in` at the first edge with `load` = 1.
- Decrement latency: one edge per low `enablen` cycle; all borrow-chain digits update on the same edge.
- `done` rises on the same edge that makes `count` zero and falls on the next edge.
- `rco_L` goes low in the same cycle `count` becomes zero.
- Simultaneous `load` and `enablen` low: load wins, and no decrement is applied that cycle.
- `rst` asserted mid-count: `count` = 0 at that edge, and `done` is forced to 0 (any pending pulse is cancelled).
- `load` asserted on the zero-reaching cycle: the load wins and `done` stays 0.

## Configuration
- Macro: `BCD_DOWN_CHAIN_AUTO_RELOAD_EN`.
- Defined:
  - A reload register captures the clamped `in` on every load; reset clears it to 0.
  - Counting with `enablen` low while `count` is all-zero reloads `count` from that register on the next edge, giving a periodic timer.
  - `done` still pulses on reaching zero.
  - If the reload register holds 0, `count` stays at 0.
- Undefined: the reload register does not exist, and `count` holds at zero (one-shot).

## Test plan
- Reset: `DIGITS`=4, mask `4'b0010`, assert `rst` one cycle → `count`=`16'h0000`, `rco_L`=0, `done`=0.
- Borrow chain: load `16'h0100`, `enablen` low one cycle → `16'h0059`; next cycle → `16'h0058`.
- Over-range seconds: load `16'h0075`, 75 decrements → `16'h0000`.
  - After 15 decrements `count` = `16'h0060`; after 16 it is `16'h0059`.
  - `done` pulses exactly once, on the edge reaching zero.
- Clamp and priority:
  - Load `16'h00AF` → `16'h0099`.
  - `load` with `enablen` low, `in`=`16'h0003` → `16'h0003` with no decrement.
  - `rst` together with `load` → `16'h0000`.
- Terminal hold:
  - Without the macro: count from `16'h0001` → 0, then 5 more enabled cycles → stays 0, `done` high once.
  - With the macro defined: the cycle after reaching 0 gives `count`=`16'h0001`, and `done` pulses every 2 enabled cycles.
- Pause: load `16'h0010`, alternate `enablen` high/low for 10 cycles → exactly 5 decrements, giving `count`=`16'h0005`.
